// File: rtl/sal_bank_fsm.sv
// sal_bank_fsm
//   Per-bank command sequencer for the DDR2 controller (open-page policy).
//   Turns the head-of-line read/write request into ACT / RD / WR / PRE commands,
//   closes the bank on a refresh request, and keeps it closed while refresh is
//   requested. It owns the bank timing counters tRCD, tRAS, tRP, tCCD and tWRPRE.
//   Each counter is reloaded on the relevant command handshake. It then gates the
//   next command that depends on it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   head-of-line request; ready pulses in the RD/WR
//                               handshake cycle
//   req_wr_i, req_row_i,
//   req_col_i                   request direction, row and column
//   cmd_valid_o / cmd_ready_i   registered command handshake to the arbiter
//   cmd_o                       0=ACT 1=RD 2=WR 3=PRE
//   cmd_addr_o                  row for ACT, zero-extended column for RD/WR, 0 for PRE
//   ref_req_i / ref_ack_o       refresh close request / bank closed and tRP met
//   row_open_o, open_row_o      open-row tracking
module sal_bank_fsm #(
    parameter int CNTR_WIDTH = 4,
    parameter int ROW_WIDTH  = 14,
    parameter int COL_WIDTH  = 10,
    parameter int T_RCD      = 3,
    parameter int T_RAS      = 8,
    parameter int T_RP       = 3,
    parameter int T_CCD      = 2,
    parameter int T_RTP      = 2,
    parameter int T_WR       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_wr_i,
    input  logic [ROW_WIDTH-1:0] req_row_i,
    input  logic [COL_WIDTH-1:0] req_col_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [1:0]           cmd_o,
    output logic [ROW_WIDTH-1:0] cmd_addr_o,
    input  logic                 ref_req_i,
    output logic                 ref_ack_o,
    output logic                 row_open_o,
    output logic [ROW_WIDTH-1:0] open_row_o
);

    typedef enum logic [1:0] {
        ST_CLOSED   = 2'd0,
        ST_OPEN     = 2'd1,
        ST_CMD_PEND = 2'd2
    } state_t;

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    localparam int NUM_CNT   = 5;
    localparam int IDX_RCD   = 0;
    localparam int IDX_RAS   = 1;
    localparam int IDX_RP    = 2;
    localparam int IDX_CCD   = 3;
    localparam int IDX_WRPRE = 4;

    // A counter loaded in handshake cycle n holds T-1 in cycle n+1 and reaches 0
    // in cycle n+T, which is when the constraint is truly met (used by ref_ack).
    // Commands are decided one cycle before they appear on cmd_valid_o, so the
    // decision gate opens when the counter is <= 1. That makes the dependent
    // handshake land exactly on n+T. A T of 1 still costs two cycles because no
    // new command is chosen in a handshake cycle.
    localparam logic [CNTR_WIDTH-1:0] LD_RCD = CNTR_WIDTH'((T_RCD > 1) ? (T_RCD - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] LD_RAS = CNTR_WIDTH'((T_RAS > 1) ? (T_RAS - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] LD_RP  = CNTR_WIDTH'((T_RP  > 1) ? (T_RP  - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] LD_CCD = CNTR_WIDTH'((T_CCD > 1) ? (T_CCD - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] LD_RTP = CNTR_WIDTH'((T_RTP > 1) ? (T_RTP - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] LD_WR  = CNTR_WIDTH'((T_WR  > 1) ? (T_WR  - 1) : 0);
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic                   cmd_valid_reg, cmd_valid_next;
    logic [1:0]             cmd_reg, cmd_next;
    logic [ROW_WIDTH-1:0]   cmd_addr_reg, cmd_addr_next;
    logic                   row_open_reg, row_open_next;
    logic [ROW_WIDTH-1:0]   open_row_reg, open_row_next;

    logic                   hs;
    logic [NUM_CNT-1:0]     cnt_ld;
    logic [CNTR_WIDTH-1:0]  cnt_ld_val [NUM_CNT];
    logic [CNTR_WIDTH-1:0]  cnt_val    [NUM_CNT];
    logic [CNTR_WIDTH-1:0]  cnt_dec    [NUM_CNT];
    logic [NUM_CNT-1:0]     cnt_go;
    logic [CNTR_WIDTH-1:0]  wrpre_floor;
    logic [ROW_WIDTH-1:0]   col_ext;
    logic                   row_hit;

    assign hs = cmd_valid_reg & cmd_ready_i;

    // ---------------------------------------------------------------------
    // Timing counters: saturate at zero, a reload wins over the decrement.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNTR_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_ld[gi]) begin
                    cnt_reg <= cnt_ld_val[gi];
                end else begin
                    cnt_reg <= cnt_dec[gi];
                end
            end

            assign cnt_val[gi] = cnt_reg;
            assign cnt_dec[gi] = (cnt_reg == '0) ? '0 : (cnt_reg - CNT_ONE);
            assign cnt_go[gi]  = (cnt_reg <= CNT_ONE);
        end
    endgenerate

    // tWRPRE only ever extends: a RD after a WR must not shorten write recovery.
    assign wrpre_floor = (cmd_reg == CMD_WR) ? LD_WR : LD_RTP;

    always_comb begin
        cnt_ld = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_ld_val[i] = '0;
        end
        if (hs) begin
            case (cmd_reg)
                CMD_ACT: begin
                    cnt_ld[IDX_RCD]     = 1'b1;
                    cnt_ld_val[IDX_RCD] = LD_RCD;
                    cnt_ld[IDX_RAS]     = 1'b1;
                    cnt_ld_val[IDX_RAS] = LD_RAS;
                end
                CMD_RD, CMD_WR: begin
                    cnt_ld[IDX_CCD]       = 1'b1;
                    cnt_ld_val[IDX_CCD]   = LD_CCD;
                    cnt_ld[IDX_WRPRE]     = 1'b1;
                    cnt_ld_val[IDX_WRPRE] = (cnt_dec[IDX_WRPRE] > wrpre_floor) ?
                                            cnt_dec[IDX_WRPRE] : wrpre_floor;
                end
                default: begin // CMD_PRE
                    cnt_ld[IDX_RP]     = 1'b1;
                    cnt_ld_val[IDX_RP] = LD_RP;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Command decision / state machine
    // ---------------------------------------------------------------------
    always_comb begin
        col_ext                  = '0;
        col_ext[COL_WIDTH-1:0]   = req_col_i;
    end

    assign row_hit = (req_row_i == open_row_reg);

    always_comb begin
        state_next     = state_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_next       = cmd_reg;
        cmd_addr_next  = cmd_addr_reg;
        row_open_next  = row_open_reg;
        open_row_next  = open_row_reg;

        case (state_reg)
            ST_CLOSED: begin
                if (req_valid_i && !ref_req_i && cnt_go[IDX_RP]) begin
                    state_next     = ST_CMD_PEND;
                    cmd_valid_next = 1'b1;
                    cmd_next       = CMD_ACT;
                    cmd_addr_next  = req_row_i;
                end
            end
            ST_OPEN: begin
                // Refresh outranks a row hit; a miss also needs the bank closed.
                if (ref_req_i || (req_valid_i && !row_hit)) begin
                    if (cnt_go[IDX_RAS] && cnt_go[IDX_WRPRE]) begin
                        state_next     = ST_CMD_PEND;
                        cmd_valid_next = 1'b1;
                        cmd_next       = CMD_PRE;
                        cmd_addr_next  = '0;
                    end
                end else if (req_valid_i) begin
                    if (cnt_go[IDX_RCD] && cnt_go[IDX_CCD]) begin
                        state_next     = ST_CMD_PEND;
                        cmd_valid_next = 1'b1;
                        cmd_next       = req_wr_i ? CMD_WR : CMD_RD;
                        cmd_addr_next  = col_ext;
                    end
                end
            end
            ST_CMD_PEND: begin
                // The pending command is held untouched until accepted.
                if (cmd_ready_i) begin
                    cmd_valid_next = 1'b0;
                    if (cmd_reg == CMD_PRE) begin
                        state_next    = ST_CLOSED;
                        row_open_next = 1'b0;
                    end else begin
                        state_next = ST_OPEN;
                        if (cmd_reg == CMD_ACT) begin
                            row_open_next = 1'b1;
                            open_row_next = cmd_addr_reg;
                        end
                    end
                end
            end
            default: begin
                state_next     = ST_CLOSED;
                cmd_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_CLOSED;
            cmd_valid_reg <= 1'b0;
            cmd_reg       <= CMD_ACT;
            cmd_addr_reg  <= '0;
            row_open_reg  <= 1'b0;
            open_row_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_reg       <= cmd_next;
            cmd_addr_reg  <= cmd_addr_next;
            row_open_reg  <= row_open_next;
            open_row_reg  <= open_row_next;
        end
    end

    assign cmd_valid_o = cmd_valid_reg;
    assign cmd_o       = cmd_reg;
    assign cmd_addr_o  = cmd_addr_reg;
    assign row_open_o  = row_open_reg;
    assign open_row_o  = open_row_reg;
    assign req_ready_o = hs & ((cmd_reg == CMD_RD) | (cmd_reg == CMD_WR));
    assign ref_ack_o   = ref_req_i & (state_reg == ST_CLOSED) &
                         (cnt_val[IDX_RP] == '0) & ~cmd_valid_reg;

endmodule

// File: tb/tb_sal_bank_fsm.sv
// tb_sal_bank_fsm
//   Directed bench for sal_bank_fsm with default parameters: a per-cycle vector
//   table for the closed-bank read and row-hit streaming cases, plus hand-written
//   sequences for row miss, refresh, backpressure and mid-command reset.
module tb_sal_bank_fsm;

    localparam int RW = 14;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_wr_i = 1'b0;
    logic [RW-1:0] req_row_i = '0;
    logic [CW-1:0] req_col_i = '0;
    logic          cmd_valid_o;
    logic          cmd_ready_i = 1'b1;
    logic [1:0]    cmd_o;
    logic [RW-1:0] cmd_addr_o;
    logic          ref_req_i = 1'b0;
    logic          ref_ack_o;
    logic          row_open_o;
    logic [RW-1:0] open_row_o;

    sal_bank_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_wr_i    (req_wr_i),
        .req_row_i   (req_row_i),
        .req_col_i   (req_col_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_o       (cmd_o),
        .cmd_addr_o  (cmd_addr_o),
        .ref_req_i   (ref_req_i),
        .ref_ack_o   (ref_ack_o),
        .row_open_o  (row_open_o),
        .open_row_o  (open_row_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [1:0]    cmd;
        logic [RW-1:0] addr;
    } hs_t;

    typedef struct {
        logic          wr;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } req_t;

    typedef struct {
        logic          rv;
        logic          wr;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          rdy;
        logic          e_val;
        logic [1:0]    e_cmd;
        logic [RW-1:0] e_addr;
        logic          e_rr;
        logic          e_ro;
        logic [RW-1:0] e_orow;
    } vec_t;

    hs_t  hs_q[$];
    hs_t  exp_q[$];
    req_t req_q[$];
    vec_t vtab[11];

    // One line per accepted command.
    always @(negedge clk) begin
        if (rst_n && cmd_valid_o && cmd_ready_i) begin
            hs_q.push_back('{cyc, cmd_o, cmd_addr_o});
            $display("hs cyc=%0d cmd=%0d addr=0x%0h", cyc, cmd_o, cmd_addr_o);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_wr_i    = 1'b0;
        req_row_i   = '0;
        req_col_i   = '0;
        ref_req_i   = 1'b0;
        cmd_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_q.delete();
    endtask

    // Compare logged handshakes (cycles relative to the first) with exp_q.
    task automatic check_hs(input string tag);
        int n;
        chk($sformatf("%s hs_count", tag), hs_q.size(), exp_q.size());
        n = (hs_q.size() < exp_q.size()) ? hs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s hs%0d cmd", tag, i), hs_q[i].cmd, exp_q[i].cmd);
            chk($sformatf("%s hs%0d addr", tag, i), hs_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s hs%0d cycle", tag, i), hs_q[i].cyc - hs_q[0].cyc, exp_q[i].cyc);
        end
    endtask

    // Presents req_q head-first, popping each entry once it is consumed.
    // Cycle t=0 is the ACT decision, so the ACT handshake is t=1 (relative 0).
    task automatic run_reqs(input int ncyc, input bit do_ref);
        for (int t = 0; t < ncyc; t++) begin
            int rel;
            bit took;
            rel = t - 1;
            ref_req_i = do_ref && (rel >= 4) && (rel < 14);
            if (req_q.size() > 0) begin
                req_valid_i = 1'b1;
                req_wr_i    = req_q[0].wr;
                req_row_i   = req_q[0].row;
                req_col_i   = req_q[0].col;
            end else begin
                req_valid_i = 1'b0;
            end
            @(negedge clk);
            if (do_ref)
                chk($sformatf("ref_ack rel%0d", rel), ref_ack_o, (rel >= 11) && (rel < 14));
            took = req_ready_o;
            @(posedge clk);
            #1;
            if (took && req_q.size() > 0) void'(req_q.pop_front());
        end
        ref_req_i   = 1'b0;
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset state and idle closed bank ----
        #3;
        chk("rst cmd_valid", cmd_valid_o, 0);
        chk("rst cmd", cmd_o, 0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d outs", i),
                {cmd_valid_o, cmd_o, cmd_addr_o, req_ready_o, ref_ack_o, row_open_o, open_row_o}, 0);
            @(posedge clk);
            #1;
        end
        // Refresh on an idle bank is acknowledged at once and blocks ACT.
        ref_req_i   = 1'b1;
        req_valid_i = 1'b1;
        req_row_i   = 14'h055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ref%0d ack", i), ref_ack_o, 1);
            chk($sformatf("idle_ref%0d no_act", i), cmd_valid_o, 0);
            @(posedge clk);
            #1;
        end

        // ---- 2 + 3: closed-bank read, then two row-hit reads ----
        //          rv    wr    row      col     rdy | val  cmd   addr     rr    ro    orow
        vtab[0]  = '{1'b1, 1'b0, 14'h012, 10'h005, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b0, 14'h000};
        vtab[1]  = '{1'b1, 1'b0, 14'h012, 10'h005, 1'b1, 1'b1, 2'd0, 14'h012, 1'b0, 1'b0, 14'h000};
        vtab[2]  = '{1'b1, 1'b0, 14'h012, 10'h005, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        vtab[3]  = '{1'b1, 1'b0, 14'h012, 10'h005, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        vtab[4]  = '{1'b1, 1'b0, 14'h012, 10'h005, 1'b1, 1'b1, 2'd1, 14'h005, 1'b1, 1'b1, 14'h012};
        vtab[5]  = '{1'b1, 1'b0, 14'h012, 10'h006, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        vtab[6]  = '{1'b1, 1'b0, 14'h012, 10'h006, 1'b1, 1'b1, 2'd1, 14'h006, 1'b1, 1'b1, 14'h012};
        vtab[7]  = '{1'b1, 1'b0, 14'h012, 10'h007, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        vtab[8]  = '{1'b1, 1'b0, 14'h012, 10'h007, 1'b1, 1'b1, 2'd1, 14'h007, 1'b1, 1'b1, 14'h012};
        vtab[9]  = '{1'b0, 1'b0, 14'h000, 10'h000, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        vtab[10] = '{1'b0, 1'b0, 14'h000, 10'h000, 1'b1, 1'b0, 2'd0, 14'h000, 1'b0, 1'b1, 14'h012};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req_valid_i = vtab[i].rv;
            req_wr_i    = vtab[i].wr;
            req_row_i   = vtab[i].row;
            req_col_i   = vtab[i].col;
            cmd_ready_i = vtab[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d cmd_valid", i), cmd_valid_o, vtab[i].e_val);
            if (vtab[i].e_val) begin
                chk($sformatf("vec%0d cmd", i), cmd_o, vtab[i].e_cmd);
                chk($sformatf("vec%0d cmd_addr", i), cmd_addr_o, vtab[i].e_addr);
            end
            chk($sformatf("vec%0d req_ready", i), req_ready_o, vtab[i].e_rr);
            chk($sformatf("vec%0d row_open", i), row_open_o, vtab[i].e_ro);
            chk($sformatf("vec%0d open_row", i), open_row_o, vtab[i].e_orow);
            @(posedge clk);
            #1;
        end

        // ---- 4: row miss after a read ----
        do_reset();
        req_q.delete();
        req_q.push_back('{1'b0, 14'h012, 10'h005});
        req_q.push_back('{1'b0, 14'h034, 10'h009});
        run_reqs(25, 1'b0);
        exp_q.delete();
        exp_q.push_back('{0,  2'd0, 14'h012});
        exp_q.push_back('{3,  2'd1, 14'h005});
        exp_q.push_back('{8,  2'd3, 14'h000});
        exp_q.push_back('{11, 2'd0, 14'h034});
        exp_q.push_back('{14, 2'd1, 14'h009});
        check_hs("miss");
        chk("miss open_row", open_row_o, 14'h034);

        // ---- 5: write, then refresh held 10 cycles over a waiting row hit ----
        do_reset();
        req_q.delete();
        req_q.push_back('{1'b1, 14'h012, 10'h003});
        req_q.push_back('{1'b0, 14'h012, 10'h004});
        run_reqs(30, 1'b1);
        exp_q.delete();
        exp_q.push_back('{0,  2'd0, 14'h012});
        exp_q.push_back('{3,  2'd2, 14'h003});
        exp_q.push_back('{8,  2'd3, 14'h000});
        exp_q.push_back('{15, 2'd0, 14'h012});
        exp_q.push_back('{18, 2'd1, 14'h004});
        check_hs("ref");

        // ---- 6: backpressure on a pending RD, then reset mid-pend ----
        do_reset();
        req_valid_i = 1'b1;
        req_wr_i    = 1'b0;
        req_row_i   = 14'h012;
        req_col_i   = 10'h005;
        for (int t = 0; t < 9; t++) begin
            if (t >= 2) cmd_ready_i = 1'b0;
            @(negedge clk);
            if (t >= 4) begin
                chk($sformatf("bp%0d cmd_valid", t), cmd_valid_o, 1);
                chk($sformatf("bp%0d cmd", t), cmd_o, 1);
                chk($sformatf("bp%0d cmd_addr", t), cmd_addr_o, 14'h005);
                chk($sformatf("bp%0d req_ready", t), req_ready_o, 0);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rstmid cmd_valid", cmd_valid_o, 0);
        chk("rstmid cmd", cmd_o, 0);
        chk("rstmid cmd_addr", cmd_addr_o, 0);
        chk("rstmid row_open", row_open_o, 0);
        chk("rstmid hs_count", hs_q.size(), 1);
        req_valid_i = 1'b0;
        cmd_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d closed", i), {cmd_valid_o, row_open_o, req_ready_o}, 0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
